adc_scan_sequencer: RTL

Sequences the external ADC front-end through channels 0..N-1 and delivers captured samples to the raw-sample register file. Scans are triggered by the CTRL.START (continuous mode) and ADC_CMD.SNAPSHOT (single scan) pulses from the Wishbone register block, and are gated by CTRL.ENABLE. The block owns the req/ack handshake to the ADC, the inter-scan period timer and the per-conversion timeout.

---
 rtl/adc_scan_sequencer_pkg.sv | 20 ++
 rtl/adc_seq_timer.sv | 37 +++
 rtl/adc_scan_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_sequencer_pkg.sv
// rtl/adc_scan_sequencer_pkg.sv - shared state encoding and constants for the ADC scan sequencer
package adc_scan_sequencer_pkg;

    localparam int NUM_CH_MAX = 8;
    localparam int CH_W       = $clog2(NUM_CH_MAX);

    localparam logic [31:0] ADC_SENTINEL = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_PER = 2'd2
    } seq_state_e;

    // Channel count with anything above the hardware maximum clamped down.
    function automatic logic [3:0] clamp_num_ch(input logic [3:0] n);
        return (n > 4'(NUM_CH_MAX)) ? 4'(NUM_CH_MAX) : n;
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// rtl/adc_seq_timer.sv - loadable saturating down-counter with zero flag
module adc_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - ADC channel scan sequencer; conversion timeout enabled by ADC_SEQ_TIMEOUT_EN
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int ADC_W       = 24,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             ctrl_enable,
    input  logic             ctrl_start,
    input  logic             snapshot,
    input  logic [3:0]       num_ch,
    input  logic [15:0]      scan_period,
    input  logic             err_clr,
    output logic             adc_req,
    output logic [CH_W-1:0]  adc_ch,
    input  logic             adc_ack,
    input  logic [ADC_W-1:0] adc_data,
    output logic             sample_valid,
    output logic [CH_W-1:0]  sample_ch,
    output logic [31:0]      sample_data,
    output logic             scan_done,
    output logic             busy,
    output logic             err_timeout,
    output logic [31:0]      scan_count
);

    seq_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [3:0]        nch_q, nch_d;
    logic [15:0]       period_q, period_d;
    logic              continuous_q, continuous_d;
    logic              snap_pend_q, snap_pend_d;
    logic              adc_req_q, adc_req_d;
    logic              sample_valid_q, sample_valid_d;
    logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
    logic [31:0]       sample_data_q, sample_data_d;
    logic              scan_done_q, scan_done_d;
    logic [31:0]       scan_count_q, scan_count_d;

    logic              start_scan;
    logic              req_rise;
    logic              conv_end;
    logic [31:0]       conv_data;
    logic              err_set;
    logic              last_ch;
    logic [3:0]        nch_clamped;

    logic              tmr_load;
    logic [15:0]       tmr_val;
    logic              tmr_dec;
    logic              tmr_zero;

    // One timer serves both the inter-scan period and the conversion timeout;
    // the two are never active at the same time.
    adc_seq_timer #(.W(16)) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign nch_clamped = clamp_num_ch(num_ch);
    assign last_ch     = ({1'b0, ch_q} + 4'd1) >= nch_q;

    // Next-state logic: scan sequencing, sample capture and trigger bookkeeping.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        nch_d          = nch_q;
        period_d       = period_q;
        continuous_d   = continuous_q;
        snap_pend_d    = snap_pend_q;
        adc_req_d      = adc_req_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        scan_done_d    = 1'b0;
        scan_count_d   = scan_count_q;
        start_scan     = 1'b0;
        req_rise       = 1'b0;
        conv_end       = 1'b0;
        conv_data      = '0;
        err_set        = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        tmr_dec        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_enable && (ctrl_start || snapshot || snap_pend_q)) begin
                    continuous_d = continuous_q | ctrl_start;
                    start_scan   = 1'b1;
                end
            end
            S_REQ: begin
                if (adc_req_q) begin
                    if (adc_ack) begin
                        conv_end  = 1'b1;
                        conv_data = {{(32-ADC_W){adc_data[ADC_W-1]}}, adc_data};
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (tmr_zero) begin
                        conv_end  = 1'b1;
                        conv_data = ADC_SENTINEL;
                        err_set   = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end else if (!ctrl_enable) begin
                    // Gap cycle after an aborted conversion: stop without scan_done.
                    state_d      = S_IDLE;
                    continuous_d = 1'b0;
                    snap_pend_d  = 1'b0;
                end else if (!last_ch) begin
                    ch_d      = ch_q + 1'b1;
                    adc_req_d = 1'b1;
                    req_rise  = 1'b1;
                end else if (continuous_q) begin
                    if (period_q == 16'd0) begin
                        start_scan = 1'b1;
                    end else begin
                        state_d  = S_WAIT_PER;
                        tmr_load = 1'b1;
                        tmr_val  = period_q - 16'd1;
                    end
                end else if (snap_pend_q) begin
                    start_scan = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_PER: begin
                if (!ctrl_enable) begin
                    state_d      = S_IDLE;
                    continuous_d = 1'b0;
                    snap_pend_d  = 1'b0;
                end else if (tmr_zero) begin
                    start_scan = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A finished conversion (ack or timeout) always produces a sample;
        // scan_done only accompanies the last channel of an uninterrupted scan.
        if (conv_end) begin
            adc_req_d      = 1'b0;
            sample_valid_d = 1'b1;
            sample_ch_d    = ch_q;
            sample_data_d  = conv_data;
            if (ctrl_enable && last_ch) begin
                scan_done_d  = 1'b1;
                scan_count_d = scan_count_q + 32'd1;
            end
        end

        // Scan start latches the scan shape; an empty scan completes immediately.
        if (start_scan) begin
            snap_pend_d = 1'b0;
            ch_d        = '0;
            nch_d       = nch_clamped;
            period_d    = scan_period;
            if (nch_clamped == 4'd0) begin
                scan_done_d  = 1'b1;
                scan_count_d = scan_count_q + 32'd1;
                state_d      = S_IDLE;
                continuous_d = 1'b0;
            end else begin
                state_d   = S_REQ;
                adc_req_d = 1'b1;
                req_rise  = 1'b1;
            end
        end

        // Triggers arriving mid-scan: start wins over a simultaneous snapshot.
        if ((state_q != S_IDLE) && ctrl_enable) begin
            if (ctrl_start) begin
                continuous_d = 1'b1;
            end else if (snapshot) begin
                snap_pend_d = 1'b1;
            end
        end

`ifdef ADC_SEQ_TIMEOUT_EN
        if (req_rise) begin
            tmr_load = 1'b1;
            tmr_val  = 16'(TIMEOUT_CYC - 1);
        end
`endif
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            nch_q          <= '0;
            period_q       <= '0;
            continuous_q   <= 1'b0;
            snap_pend_q    <= 1'b0;
            adc_req_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            scan_done_q    <= 1'b0;
            scan_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            nch_q          <= nch_d;
            period_q       <= period_d;
            continuous_q   <= continuous_d;
            snap_pend_q    <= snap_pend_d;
            adc_req_q      <= adc_req_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            scan_done_q    <= scan_done_d;
            scan_count_q   <= scan_count_d;
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    logic err_q, err_d;

    // Sticky timeout flag; a set in the same cycle as a clear wins.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Timeout flag register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr | err_set | req_rise | (TIMEOUT_CYC == 0);
    assign err_timeout = 1'b0;
`endif

    assign adc_req      = adc_req_q;
    assign adc_ch       = ch_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign scan_done    = scan_done_q;
    assign busy         = (state_q != S_IDLE);
    assign scan_count   = scan_count_q;

endmodule
